// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register plus operand-forwarding stage feeding the EX ALU.
//   Captures decoded operands/control from ID every cycle, supports stall
//   (hold) and flush (bubble), and resolves RAW hazards by forwarding results
//   from EX/MEM and MEM/WB onto the registered rs/rt operands.
//
// Configuration macro: ALU_OPERAND_FWD_EN
//   defined   : forwarding network enabled (EX/MEM beats MEM/WB, index 0 never
//               forwarded)
//   undefined : operands come straight from the registered register-file data
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   stall, flush               hold / bubble-load the ID/EX register
//   id_*                       decoded instruction from ID
//   exmem_*, memwb_*           later-stage write info used for forwarding
//   alu_a, alu_b, alu_ctrl,
//   alu_shmnt                  operands and control to the ALU
//   ex_store_data              forwarded rt (store data)
//   ex_dst, ex_reg_write,
//   ex_valid                   destination info for EX/MEM
module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_dst,
  input  logic          id_alu_src,
  input  logic [CW-1:0] id_alu_ctrl,
  input  logic [4:0]    id_shmnt,
  input  logic          id_reg_write,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_dst,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_dst,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [CW-1:0] alu_ctrl,
  output logic [4:0]    alu_shmnt,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dst,
  output logic          ex_reg_write,
  output logic          ex_valid
);

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dst;
    logic          alu_src;
    logic [CW-1:0] alu_ctrl;
    logic [4:0]    shmnt;
  } id_ex_t;

  id_ex_t stage_q, stage_d;
  logic [DW-1:0] rs_fwd, rt_fwd;

  // Flush beats stall; an all-zero record is a bubble.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid     = id_valid;
      stage_d.reg_write = id_reg_write & id_valid;
      stage_d.rs_data   = id_rs_data;
      stage_d.rt_data   = id_rt_data;
      stage_d.imm       = id_imm;
      stage_d.rs        = id_rs;
      stage_d.rt        = id_rt;
      stage_d.dst       = id_dst;
      stage_d.alu_src   = id_alu_src;
      stage_d.alu_ctrl  = id_alu_ctrl;
      stage_d.shmnt     = id_shmnt;
    end
  end

  // Reset overrides both flush and stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

`ifdef ALU_OPERAND_FWD_EN
  // Index 0 is hard-wired zero, so it never takes a forwarded value.
  always_comb begin
    rs_fwd = stage_q.rs_data;
    if (exmem_reg_write && (exmem_dst == stage_q.rs) && (stage_q.rs != '0)) begin
      rs_fwd = exmem_result;
    end else if (memwb_reg_write && (memwb_dst == stage_q.rs) && (stage_q.rs != '0)) begin
      rs_fwd = memwb_result;
    end
  end

  always_comb begin
    rt_fwd = stage_q.rt_data;
    if (exmem_reg_write && (exmem_dst == stage_q.rt) && (stage_q.rt != '0)) begin
      rt_fwd = exmem_result;
    end else if (memwb_reg_write && (memwb_dst == stage_q.rt) && (stage_q.rt != '0)) begin
      rt_fwd = memwb_result;
    end
  end
`else
  // Without forwarding, hazards are resolved by stalling elsewhere.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{exmem_reg_write, exmem_dst, exmem_result,
                               memwb_reg_write, memwb_dst, memwb_result};
  assign rs_fwd = stage_q.rs_data;
  assign rt_fwd = stage_q.rt_data;
`endif

  assign alu_a         = rs_fwd;
  assign alu_b         = stage_q.alu_src ? stage_q.imm : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_ctrl      = stage_q.alu_ctrl;
  assign alu_shmnt     = stage_q.shmnt;
  assign ex_dst        = stage_q.dst;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_valid      = stage_q.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage
//   Self-checking bench for id_ex_operand_stage: directed scenarios plus a
//   randomized run compared against an instruction-level reference model.
//   The model follows ALU_OPERAND_FWD_EN the same way the design does.
module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int OW = 3*DW + CW + 5 + RW + 2;

  logic          clk = 1'b0;
  logic          rst_n, stall, flush, id_valid;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_dst;
  logic          id_alu_src;
  logic [CW-1:0] id_alu_ctrl;
  logic [4:0]    id_shmnt;
  logic          id_reg_write;
  logic          exmem_reg_write;
  logic [RW-1:0] exmem_dst;
  logic [DW-1:0] exmem_result;
  logic          memwb_reg_write;
  logic [RW-1:0] memwb_dst;
  logic [DW-1:0] memwb_result;
  logic [DW-1:0] alu_a, alu_b, ex_store_data;
  logic [CW-1:0] alu_ctrl;
  logic [4:0]    alu_shmnt;
  logic [RW-1:0] ex_dst;
  logic          ex_reg_write, ex_valid;

  int tests_run = 0;
  int tests_failed = 0;

  // The instruction the model believes is sitting in EX.
  typedef struct {
    bit          valid;
    bit          writes;
    bit [DW-1:0] rs_val, rt_val, imm;
    bit [RW-1:0] rs, rt, dst;
    bit          use_imm;
    bit [CW-1:0] op;
    bit [4:0]    sh;
  } instr_t;

  instr_t ex_instr;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .id_shmnt(id_shmnt),
    .id_reg_write(id_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_shmnt(alu_shmnt),
    .ex_store_data(ex_store_data), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
    .ex_valid(ex_valid)
  );

  function automatic instr_t bubble();
    instr_t b;
    b = '{default: 0};
    return b;
  endfunction

  // Value an operand register index delivers to EX right now.
  function automatic bit [DW-1:0] operand_value(bit [RW-1:0] idx, bit [DW-1:0] reg_val);
`ifdef ALU_OPERAND_FWD_EN
    if (idx == 0) return reg_val;
    if (exmem_reg_write && exmem_dst == idx) return exmem_result;
    if (memwb_reg_write && memwb_dst == idx) return memwb_result;
`endif
    return reg_val;
  endfunction

  function automatic bit [OW-1:0] expected_outputs();
    bit [DW-1:0] a, b, st;
    a  = operand_value(ex_instr.rs, ex_instr.rs_val);
    st = operand_value(ex_instr.rt, ex_instr.rt_val);
    b  = ex_instr.use_imm ? ex_instr.imm : st;
    return {a, b, ex_instr.op, ex_instr.sh, st, ex_instr.dst, ex_instr.writes, ex_instr.valid};
  endfunction

  // One clock: the model takes the same decision the pipeline register should.
  task automatic tick();
    @(posedge clk);
    if (!rst_n || flush) begin
      ex_instr = bubble();
    end else if (!stall) begin
      ex_instr.valid   = id_valid;
      ex_instr.writes  = id_valid && id_reg_write;
      ex_instr.rs_val  = id_rs_data;
      ex_instr.rt_val  = id_rt_data;
      ex_instr.imm     = id_imm;
      ex_instr.rs      = id_rs;
      ex_instr.rt      = id_rt;
      ex_instr.dst     = id_dst;
      ex_instr.use_imm = id_alu_src;
      ex_instr.op      = id_alu_ctrl;
      ex_instr.sh      = id_shmnt;
    end
    #1;
  endtask

  task automatic randomize_id();
    id_valid     = 1'($urandom);
    id_rs_data   = $urandom;
    id_rt_data   = $urandom;
    id_imm       = $urandom;
    id_rs        = RW'($urandom);
    id_rt        = RW'($urandom);
    id_dst       = RW'($urandom);
    id_alu_src   = 1'($urandom);
    id_alu_ctrl  = CW'($urandom);
    id_shmnt     = 5'($urandom);
    id_reg_write = 1'($urandom);
  endtask

  task automatic quiet_forwarding();
    exmem_reg_write = 1'b0; exmem_dst = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_dst = '0; memwb_result = '0;
  endtask

  task automatic test_reset();
    bit [OW-1:0] obs;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      randomize_id();
      exmem_reg_write = 1'b1; exmem_dst = RW'($urandom_range(1, 31)); exmem_result = $urandom;
      memwb_reg_write = 1'b1; memwb_dst = RW'($urandom_range(1, 31)); memwb_result = $urandom;
      tick();
      obs = {alu_a, alu_b, alu_ctrl, alu_shmnt, ex_store_data, ex_dst, ex_reg_write, ex_valid};
      tests_run++;
      if (obs !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset cycle %0d: outputs got %h expected 0", i, obs);
      end
    end
    rst_n = 1'b1;
    quiet_forwarding();
  endtask

  task automatic test_capture();
    randomize_id();
    id_valid = 1'b1; id_rs = 5'd1; id_rs_data = 32'd5; id_imm = 32'd7;
    id_alu_src = 1'b1; id_alu_ctrl = 4'b0010; id_reg_write = 1'b1;
    tick();
    tests_run++;
    if ({alu_a, alu_b, alu_ctrl, ex_valid, ex_reg_write} !== {32'd5, 32'd7, 4'd2, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL capture: a=%h b=%h ctrl=%h v=%b rw=%b expected 5 7 2 1 1",
               alu_a, alu_b, alu_ctrl, ex_valid, ex_reg_write);
    end
    // A write from an invalid slot must not survive into EX.
    id_valid = 1'b0; id_reg_write = 1'b1;
    tick();
    tests_run++;
    if ({ex_valid, ex_reg_write} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL capture_invalid: v/rw got %b expected 00", {ex_valid, ex_reg_write});
    end
  endtask

  task automatic test_forward_priority();
    bit [DW-1:0] exp_a;
    randomize_id();
    id_valid = 1'b1; id_rs = 5'd3; id_rs_data = 32'h0000_0011;
    tick();
    exmem_reg_write = 1'b1; exmem_dst = 5'd3; exmem_result = 32'hAAAA_0000;
    memwb_reg_write = 1'b1; memwb_dst = 5'd3; memwb_result = 32'h0000_1234;
    #1;
`ifdef ALU_OPERAND_FWD_EN
    exp_a = 32'hAAAA_0000;
`else
    exp_a = 32'h0000_0011;
`endif
    tests_run++;
    if (alu_a !== exp_a) begin
      tests_failed++;
      $display("[TB] FAIL fwd_exmem_priority: alu_a got %h expected %h", alu_a, exp_a);
    end
    exmem_reg_write = 1'b0;
    #1;
`ifdef ALU_OPERAND_FWD_EN
    exp_a = 32'h0000_1234;
`else
    exp_a = 32'h0000_0011;
`endif
    tests_run++;
    if (alu_a !== exp_a) begin
      tests_failed++;
      $display("[TB] FAIL fwd_memwb: alu_a got %h expected %h", alu_a, exp_a);
    end
    // Forwarding keeps working while the register holds.
    stall = 1'b1; randomize_id();
    memwb_result = 32'h0BAD_F00D;
    tick();
`ifdef ALU_OPERAND_FWD_EN
    exp_a = 32'h0BAD_F00D;
`else
    exp_a = 32'h0000_0011;
`endif
    tests_run++;
    if (alu_a !== exp_a) begin
      tests_failed++;
      $display("[TB] FAIL fwd_during_stall: alu_a got %h expected %h", alu_a, exp_a);
    end
    stall = 1'b0;
    quiet_forwarding();
  endtask

  task automatic test_zero_register();
    randomize_id();
    id_valid = 1'b1; id_rt = 5'd0; id_rt_data = 32'd0; id_alu_src = 1'b0;
    tick();
    exmem_reg_write = 1'b1; exmem_dst = 5'd0; exmem_result = 32'hFFFF_FFFF;
    memwb_reg_write = 1'b1; memwb_dst = 5'd0; memwb_result = 32'hFFFF_FFFF;
    #1;
    tests_run++;
    if ({alu_b, ex_store_data} !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL zero_reg: alu_b=%h store=%h expected 0 0", alu_b, ex_store_data);
    end
    quiet_forwarding();
  endtask

  task automatic test_stall_flush();
    randomize_id();
    id_valid = 1'b1; id_reg_write = 1'b1; id_alu_ctrl = 4'b0110;
    id_dst = 5'd7; id_shmnt = 5'd9;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_id();
      tick();
      tests_run++;
      if ({alu_ctrl, ex_dst, alu_shmnt, ex_valid, ex_reg_write} !== {4'd6, 5'd7, 5'd9, 1'b1, 1'b1}) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold cycle %0d: ctrl=%h dst=%0d sh=%0d v=%b rw=%b expected 6 7 9 1 1",
                 i, alu_ctrl, ex_dst, alu_shmnt, ex_valid, ex_reg_write);
      end
    end
    flush = 1'b1;
    tick();
    tests_run++;
    if ({ex_valid, ex_reg_write, alu_ctrl, ex_dst, alu_a} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL flush_beats_stall: v=%b rw=%b ctrl=%h dst=%0d a=%h expected all 0",
               ex_valid, ex_reg_write, alu_ctrl, ex_dst, alu_a);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    randomize_id();
    id_valid = 1'b1; id_reg_write = 1'b1; id_alu_ctrl = 4'hF; id_rs_data = 32'hDEAD_BEEF;
    tick();
    stall = 1'b1; rst_n = 1'b0;
    tick();
    tests_run++;
    if ({alu_a, alu_ctrl, ex_valid, ex_reg_write} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_stall: a=%h ctrl=%h v=%b rw=%b expected all 0",
               alu_a, alu_ctrl, ex_valid, ex_reg_write);
    end
    stall = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit [OW-1:0] obs, exp_o;
    for (int i = 0; i < 300; i++) begin
      randomize_id();
      // Small index space so forwarding hits are frequent.
      id_rs = RW'($urandom_range(0, 3));
      id_rt = RW'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 99) >= 3);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      exmem_reg_write = 1'($urandom); exmem_dst = RW'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_dst = RW'($urandom_range(0, 3)); memwb_result = $urandom;
      tick();
      obs   = {alu_a, alu_b, alu_ctrl, alu_shmnt, ex_store_data, ex_dst, ex_reg_write, ex_valid};
      exp_o = expected_outputs();
      tests_run++;
      if (obs !== exp_o) begin
        tests_failed++;
        $display("[TB] FAIL random step %0d: outputs got %h expected %h", i, obs, exp_o);
      end
    end
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    ex_instr = bubble();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    randomize_id();
    quiet_forwarding();
    test_reset();
    test_capture();
    test_forward_priority();
    test_zero_register();
    test_stall_flush();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
